identity_load_ctrl: RTL
=======================

Name: identity_load_ctrl

Overview:
- Sequencer that writes an N x N identity (or all-zero) matrix into the SVD V-matrix storage through a valid/ready write port, one element per accepted beat, in row-major order.
- The SVD control FSM pulses start before each decomposition; done tells it that V is initialised.
- Replaces free-running identity constants with an on-demand, handshaked load.

Parameters:
N, 4, matrix dimension (rows = cols)
DATA_W, 32, element width
ADDR_W, 4, write address width; must satisfy 2^ADDR_W >= N*N
ONE_VAL, 32'd1, value written on the diagonal in identity mode
ZERO_VAL, 32'd0, value written off-diagonal, and everywhere in clear mode

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a load; sampled only in IDLE
mode  input  1  latched with start; 0 = identity, 1 = clear to zero
abort  input  1  terminate the load in progress
wr_valid  output  1  write beat valid
wr_ready  input  1  storage accepts the beat
wr_addr  output  ADDR_W  element address = row*N + col
wr_data  output  DATA_W  element value
busy  output  1  high in LOAD and DONE
done  output  1  one-cycle pulse when all N*N beats are accepted

Behaviour:
- Reset (async, rst=1): state=IDLE; wr_valid=0, wr_addr=0, wr_data=ZERO_VAL, busy=0, done=0, row=col=0, mode_q=0.
- All outputs are registered.
- States: IDLE, LOAD, DONE.
- IDLE:
  - start=1 latches mode_q=mode, clears row and col, and moves to LOAD.
  - At that same edge, wr_valid=1, wr_addr=0, and wr_data is set for element (0,0).
  - Latency: start seen at edge k gives wr_valid high from edge k onward.
- LOAD:
  - wr_valid=1 throughout.
  - wr_data = ONE_VAL if (mode_q==0 && row==col); otherwise ZERO_VAL.
  - While wr_valid && !wr_ready, wr_addr and wr_data are held stable, with no advance.
  - On wr_valid && wr_ready:
    - if col==N-1 then col=0 and row=row+1; otherwise col=col+1.
    - Outputs present the next element at the same edge, which supports back-to-back beats.
  - Acceptance of element (N-1,N-1): go to DONE; wr_valid=0, wr_addr=0, done=1.
- DONE: lasts exactly one cycle (done=1, busy=1), then IDLE with done=0.
- start is ignored in LOAD and DONE; no queuing.
- abort:
  - Effective only in LOAD. Go to IDLE, wr_valid=0, done is never asserted, and row, col and wr_addr are cleared.
  - abort in the same cycle as an accepted beat: the beat counts as written at the storage, but the FSM still aborts (abort wins).
  - abort in IDLE or DONE has no effect; a done pulse already in progress completes.
- Throughput with wr_ready held high: N*N consecutive beats, then one done cycle. Total is N*N+1 cycles from the first valid to done inclusive.
- Counters are sized to clog2(N). row never exceeds N-1, because the transition to DONE occurs before any wrap.
- Reset mid-LOAD: immediate async return to the reset values; any partial load is abandoned.
- Start at the same edge as rst deassertion: ignored, since rst still holds the state.

Test Plan:
- Identity, ready always 1: pulse start with mode=0 -> 16 beats at addr 0..15. Data is 1 at addr 0, 5, 10, 15 and 0 elsewhere. done pulses exactly 1 cycle, on the cycle after the beat at addr 15; busy is high for 17 cycles.
- Backpressure: hold wr_ready=0 for 3 cycles at addr 5 -> wr_addr=5 and wr_data=1 stay stable for 4 cycles. The sequence resumes at addr 6 with no skip or duplicate.
- Clear mode: start with mode=1 and random wr_ready -> all 16 accepted beats carry data 0 in order 0..15, and done=1 once.
- Abort: assert abort during the beat at addr 7 while wr_ready=1 -> wr_valid=0 next cycle, done never asserted, busy=0. A following start restarts at addr 0.
- Start while busy: pulse start at addr 3 with mode=1 -> ignored; the identity load continues unchanged and done pulses once.
- Async reset: assert rst mid-LOAD between clock edges -> wr_valid, busy and done are 0 immediately. After release, no beats appear until a new start.

Source files
------------

// File: rtl/identity_load_ctrl.sv
// Handshaked loader that streams an N x N identity or zero matrix
// into V-matrix storage, one element per accepted beat, row-major.
module identity_load_ctrl #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter logic [DATA_W-1:0] ONE_VAL  = {{(DATA_W-1){1'b0}}, 1'b1},
  parameter logic [DATA_W-1:0] ZERO_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [RW-1:0]     row_q, row_d;
  logic [RW-1:0]     col_q, col_d;
  logic              mode_q, mode_d;
  logic              valid_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              last;

  assign last = (row_q == LAST) && (col_q == LAST);

  function automatic logic [ADDR_W-1:0] elem_addr(
    input logic [RW-1:0] r,
    input logic [RW-1:0] c
  );
    return ADDR_W'(r) * ADDR_W'(N) + ADDR_W'(c);
  endfunction

  function automatic logic [DATA_W-1:0] elem_data(
    input logic          m,
    input logic [RW-1:0] r,
    input logic [RW-1:0] c
  );
    return (!m && r == c) ? ONE_VAL : ZERO_VAL;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      mode_q   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= ZERO_VAL;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      mode_q   <= mode_d;
      wr_valid <= valid_d;
      wr_addr  <= addr_d;
      wr_data  <= data_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (abort)                state_d = S_IDLE;
        else if (wr_ready && last) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next registered outputs; a beat advance presents the next element
  // at the same edge so back-to-back beats need no bubble.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    mode_d  = mode_q;
    valid_d = wr_valid;
    addr_d  = wr_addr;
    data_d  = wr_data;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          mode_d  = mode;
          row_d   = '0;
          col_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          addr_d  = '0;
          data_d  = elem_data(mode, '0, '0);
        end
      end
      S_LOAD: begin
        if (abort) begin
          row_d   = '0;
          col_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          addr_d  = '0;
          data_d  = ZERO_VAL;
        end else if (wr_ready) begin
          if (last) begin
            row_d   = '0;
            col_d   = '0;
            valid_d = 1'b0;
            addr_d  = '0;
            data_d  = ZERO_VAL;
            done_d  = 1'b1;
          end else begin
            if (col_q == LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            addr_d = elem_addr(row_d, col_d);
            data_d = elem_data(mode_q, row_d, col_d);
          end
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
